mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multiply/divide unit for the five-stage MIPS pipeline, instantiated in the Execute stage beside the ALU. It accepts mult/multu/div/divu operations from E-stage operands, computes them over a fixed multi-cycle latency, and holds the results in the HI/LO registers. It serves mfhi/mflo/mthi/mtlo. It drives `start` and `busy` to the hazard unit, which stalls any multiply/divide-class instruction in D while `start | busy` is high.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for div/divu; legal range 1..15.
- `clk`  input  1  pipeline clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `md_op`  input  4  operation of the instruction in E:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - 9..15 are treated as none.
- `rs`  input  32  forwarded E-stage rs value (FW_e_d1).
- `rt`  input  32  forwarded E-stage rt value (FW_e_d2).
- `start`  output  1  combinational; high when `md_op` is 1..4 and the unit is not busy.
- `busy`  output  1  registered; high while an operation is in flight.
- `hi`  output  32  current HI register.
- `lo`  output  32  current LO register.
- `md_out`  output  32  combinational; `hi` when `md_op`=5, `lo` when `md_op`=6, else 0.

## Operation
- State consists of:
  - HI and LO, 32 bits each.
  - Operand latches A and B, 32 bits each.
  - A 3-bit op latch.
  - A 4-bit down-counter `cnt`.
  - `busy` is defined as `cnt != 0`.
- States:
  - IDLE when `cnt` = 0.
  - RUN when `cnt` > 0.
- IDLE behaviour:
  - On `start`, latch A=rs, B=rt and the op, and load `cnt` with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - `md_op`=7 writes HI=rs at the edge.
  - `md_op`=8 writes LO=rs at the edge.
- RUN behaviour:
  - `cnt` decrements each edge.
  - On the edge where `cnt` goes 1→0, HI/LO are written with the result computed from the latched A/B/op. Return to IDLE.
- Results:
  - mult: signed 64-bit product of A and B; HI = bits 63:32, LO = bits 31:0.
  - multu: same as mult, but the product is unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder, whose sign follows the dividend.
  - divu: LO and HI are the unsigned quotient and remainder.
  - Signed div of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000 and HI=0.
- Divide by zero (B=0): the operation still runs the full DIV_CYCLES with busy high, and HI/LO are left unchanged at completion.
- Ignored inputs while busy:
  - `md_op` 1..4 is ignored, and `start` stays low.
  - `md_op` 7/8 is ignored.
  - The hazard unit guarantees neither occurs; the unit must not corrupt state if they do.
- mfhi/mflo while busy return the pre-operation HI/LO. The hazard unit is responsible for stalling them.
- Operands are sampled only at the start edge. Later changes on rs/rt have no effect on the result.

## Timing
- Reset values:
  - HI=0, LO=0, `cnt`=0, A=B=0, op latch=0.
  - Therefore `busy`=0, `start` follows `md_op`, and `md_out` is 0 or 0 for mf ops.
- Reset asserted mid-operation aborts the operation immediately. After reset deasserts, HI/LO are 0 and `busy` is 0 without waiting for any clock edge.
- Start edge:
  - `start` is high in cycle T.
  - `busy` is high in cycles T+1..T+N, where N is MULT_CYCLES or DIV_CYCLES.
  - New HI/LO are visible in cycle T+N+1, the first cycle with `busy` low.
- Back-to-back: a new start is accepted in cycle T+N+1. HI/LO written at that edge are the previous results, and the new operation then runs.
- mthi/mtlo latency is 1 edge: the value is visible on `hi`/`lo` the next cycle.
- `start` and `busy` are never both high.

## Test plan
- Signed multiply:
  - Stimulus: reset, then mult with rs=0xFFFFFFFE (-2), rt=3.
  - Required: `start`=1 for 1 cycle, then `busy`=1 for exactly 5 cycles.
  - Required: then hi=0xFFFFFFFF and lo=0xFFFFFFFA; md_op=5 gives md_out=0xFFFFFFFF.
- Unsigned multiply:
  - Stimulus: multu with rs=rt=0xFFFFFFFF.
  - Required: after 5 busy cycles, hi=0xFFFFFFFE and lo=0x00000001.
- Signed and unsigned divide:
  - Stimulus: div with rs=-7 (0xFFFFFFF9), rt=2.
  - Required: `busy` for 10 cycles, then lo=0xFFFFFFFD and hi=0xFFFFFFFF.
  - Stimulus: divu with the same operands.
  - Required: lo=0x7FFFFFFC and hi=0x00000001.
- Divide by zero:
  - Stimulus: mthi 0x1234, then mtlo 0x5678, then div with rt=0.
  - Required: 10 busy cycles, after which hi=0x1234 and lo=0x5678.
- Busy interference:
  - Stimulus: during a mult, drive md_op=3 and md_op=7 with rs=0xDEAD.
  - Required: `start` stays 0, `busy` still falls after 5 cycles, hi/lo hold the mult result, and 0xDEAD does not appear.
- Reset mid-operation:
  - Stimulus: assert `reset` between clock edges in busy cycle 3 of a div.
  - Required: `busy`, hi and lo go to 0 immediately.
  - Required: after release, a new mult of 6×7 gives lo=42, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multiply/divide unit for the Execute stage.
// Holds the HI/LO architectural registers and runs mult/multu/div/divu over
// a fixed latency. The result is written to HI/LO on the final busy edge.
// mfhi/mflo/mthi/mtlo access HI/LO directly.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4
  } md_kind_t;

  localparam logic [3:0] MD_MFHI = 4'd5;
  localparam logic [3:0] MD_MFLO = 4'd6;
  localparam logic [3:0] MD_MTHI = 4'd7;
  localparam logic [3:0] MD_MTLO = 4'd8;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [31:0] a_lat;
  logic [31:0] b_lat;
  md_kind_t    op_lat;
  logic [3:0]  cnt;

  logic [63:0] res;
  logic        res_we;
  logic        is_mul_op;

  // Signed 32x32 -> 64 product; both operands sign-extended first.
  function automatic logic [63:0] mul_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    p  = ea * eb;
    return p;
  endfunction

  // Unsigned 32x32 -> 64 product.
  function automatic logic [63:0] mul_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {32'd0, a};
    eb = {32'd0, b};
    return ea * eb;
  endfunction

  // Unsigned divide; returns {remainder, quotient}. Zero divisor yields 0.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. Magnitude of 0x80000000 is itself
  // as an unsigned value, so 0x80000000 / -1 wraps back to 0x80000000.
  function automatic logic [63:0] div_signed(input logic signed [31:0] a,
                                             input logic signed [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    logic [63:0] qr;
    logic [31:0] q;
    logic [31:0] r;
    ma = a[31] ? 32'(-a) : 32'(a);
    mb = b[31] ? 32'(-b) : 32'(b);
    qr = div_unsigned(ma, mb);
    q  = qr[31:0];
    r  = qr[63:32];
    if (a[31] ^ b[31]) q = -q;
    if (a[31])         r = -r;
    return {r, q};
  endfunction

  assign busy      = (cnt != 4'd0);
  assign is_mul_op = (md_op == 4'd1) || (md_op == 4'd2);
  assign start     = (md_op >= 4'd1) && (md_op <= 4'd4) && !busy;

  // Read port for mfhi/mflo; other ops read as zero.
  always_comb begin
    md_out = 32'd0;
    if (md_op == MD_MFHI)      md_out = hi;
    else if (md_op == MD_MFLO) md_out = lo;
  end

  // Result of the latched operation; a zero divisor suppresses the write.
  always_comb begin
    res    = 64'd0;
    res_we = 1'b0;
    case (op_lat)
      OP_MULT: begin
        res    = mul_signed(a_lat, b_lat);
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res    = mul_unsigned(a_lat, b_lat);
        res_we = 1'b1;
      end
      OP_DIV: begin
        res    = div_signed(a_lat, b_lat);
        res_we = (b_lat != 32'd0);
      end
      OP_DIVU: begin
        res    = div_unsigned(a_lat, b_lat);
        res_we = (b_lat != 32'd0);
      end
      default: begin
        res    = 64'd0;
        res_we = 1'b0;
      end
    endcase
  end

  // Operand latch, countdown and HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      a_lat  <= 32'd0;
      b_lat  <= 32'd0;
      op_lat <= OP_NONE;
      cnt    <= 4'd0;
    end else if (cnt == 4'd0) begin
      if (start) begin
        a_lat  <= rs;
        b_lat  <= rt;
        op_lat <= md_kind_t'(md_op[2:0]);
        cnt    <= is_mul_op ? MULT_LOAD : DIV_LOAD;
      end else if (md_op == MD_MTHI) begin
        hi <= rs;
      end else if (md_op == MD_MTLO) begin
        lo <= rs;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && res_we) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: multiply, divide, divide-by-zero,
// busy interference, mthi/mtlo and asynchronous reset mid-operation.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .rs     (rs),
    .rt     (rt),
    .start  (start),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op;
    rs    = a;
    rt    = b;
    #1;
  endtask

  // Count busy cycles (bounded) and compare with the expected latency.
  task automatic wait_done(input string tag, input int n);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      c++;
      tick();
    end
    chk(tag, 32'(c), 32'(n));
  endtask

  // Start an op, confirm the handshake, then let it run to completion.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    issue(op, a, b);
    chk({tag, "_start"}, {31'd0, start}, 32'd1);
    tick();
    issue(4'd0, 32'd0, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done({tag, "_len"}, n);
  endtask

  initial begin
    reset = 1'b1;
    md_op = 4'd0;
    rs    = 32'd0;
    rt    = 32'd0;
    #2;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    issue(4'd5, 32'd0, 32'd0);
    chk("rst_mfhi", md_out, 32'd0);
    issue(4'd1, 32'd0, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd1);
    issue(4'd0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Signed multiply -2 * 3
    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    issue(4'd5, 32'd0, 32'd0);
    chk("mfhi", md_out, 32'hFFFF_FFFF);
    issue(4'd6, 32'd0, 32'd0);
    chk("mflo", md_out, 32'hFFFF_FFFA);

    // Unsigned multiply, issued back-to-back right as busy drops
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // Signed and unsigned divide of -7 by 2
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op("divu", 4'd4, 32'hFFFF_FFF9, 32'd2, 10);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'h0000_0001);

    // Signed overflow case
    run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0000_0000);

    // mthi/mtlo then divide by zero
    issue(4'd7, 32'h1234, 32'd0);
    chk("mthi_nostart", {31'd0, start}, 32'd0);
    tick();
    chk("mthi_hi", hi, 32'h1234);
    issue(4'd8, 32'h5678, 32'd0);
    tick();
    chk("mtlo_lo", lo, 32'h5678);
    run_op("div0", 4'd3, 32'd99, 32'd0, 10);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_lo", lo, 32'h5678);

    // Busy interference: div and mthi attempts during a mult
    issue(4'd1, 32'd3, 32'd5);
    chk("intf_start", {31'd0, start}, 32'd1);
    tick();
    issue(4'd3, 32'hDEAD, 32'd1);
    chk("intf_div_start", {31'd0, start}, 32'd0);
    chk("intf_div_busy", {31'd0, busy}, 32'd1);
    tick();
    issue(4'd7, 32'hDEAD, 32'd1);
    chk("intf_mthi_start", {31'd0, start}, 32'd0);
    tick();
    issue(4'd5, 32'hDEAD, 32'd0);
    chk("intf_mfhi_old", md_out, 32'h1234);
    issue(4'd0, 32'hDEAD, 32'd0);
    wait_done("intf_len", 3);
    chk("intf_hi", hi, 32'd0);
    chk("intf_lo", lo, 32'd15);

    // Reset asserted between edges in busy cycle 3 of a div
    issue(4'd7, 32'hAAAA, 32'd0);
    tick();
    chk("pre_rst_hi", hi, 32'hAAAA);
    issue(4'd3, 32'd100, 32'd7);
    tick();
    issue(4'd0, 32'd0, 32'd0);
    tick();
    tick();
    chk("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_rel_busy", {31'd0, busy}, 32'd0);
    tick();
    run_op("mult67", 4'd1, 32'd6, 32'd7, 5);
    chk("mult67_lo", lo, 32'd42);
    chk("mult67_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
